// File: rtl/rf_arbiter.sv
// rtl/rf_arbiter.sv - two-requester round-robin arbiter in front of a single-port register file
//
// Purpose: accepts one access at a time from requester 0 or 1, drives the
// register-file strobes for one cycle, and returns read data (or a timeout
// error) to whichever requester was granted.
//
// Ports:
//   CLK_IN, RST_IN           clock (rising edge), asynchronous active-low reset
//   REQn, WRn, ADDRn, WDATAn request, type (1 = write), address, write data
//   GNTn                     one-cycle accept pulse
//   RDATA, RVLDn, RD_ERR     read return data, return pulse, timeout flag
//   Address, WrEn, RdEn,     register-file address, strobes,
//   WrData                   and write data
//   RdData, RdData_Valid     register-file read data and qualifier

module rf_arbiter #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                  CLK_IN,
    input  logic                  RST_IN,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WR0,
    input  logic                  WR1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [WIDTH-1:0]      WDATA0,
    input  logic [WIDTH-1:0]      WDATA1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic [WIDTH-1:0]      RDATA,
    output logic                  RVLD0,
    output logic                  RVLD1,
    output logic                  RD_ERR,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [WIDTH-1:0]      WrData,
    input  logic [WIDTH-1:0]      RdData,
    input  logic                  RdData_Valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ACC  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    // Counter saturates at RD_TIMEOUT-1; four bits covers the full 2..15 range.
    localparam logic [3:0] TIMEOUT_LAST = 4'(RD_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    ptr_q, ptr_d;       // favoured requester
    logic                    owner_q, owner_d;   // requester of the access in flight
    logic [3:0]              cnt_q, cnt_d;

    logic                    gnt0_d, gnt1_d;
    logic                    wr_en_d, rd_en_d;
    logic                    rvld0_d, rvld1_d, rd_err_d;
    logic [WIDTH-1:0]        rdata_d, wr_data_d;
    logic [ADDR_WIDTH-1:0]   address_d;

    logic                    winner;
    logic                    is_wr;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        rvld0_d   = 1'b0;
        rvld1_d   = 1'b0;
        rd_err_d  = 1'b0;
        rdata_d   = RDATA;
        address_d = Address;
        wr_data_d = WrData;

        // Pointer only breaks ties; a lone requester always wins.
        winner = (REQ0 && REQ1) ? ptr_q : REQ1;
        is_wr  = winner ? WR1 : WR0;

        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    owner_d   = winner;
                    ptr_d     = ~winner;
                    address_d = winner ? ADDR1 : ADDR0;
                    wr_data_d = winner ? WDATA1 : WDATA0;
                    wr_en_d   = is_wr;
                    rd_en_d   = ~is_wr;
                    gnt0_d    = ~winner;
                    gnt1_d    = winner;
                    cnt_d     = 4'd0;
                    state_d   = is_wr ? WR_ACC : RD_WAIT;
                end
            end
            WR_ACC: begin
                state_d = IDLE;
            end
            RD_WAIT: begin
                // Valid data takes priority over a timeout in the same cycle.
                if (RdData_Valid) begin
                    rdata_d = RdData;
                    rvld0_d = ~owner_q;
                    rvld1_d = owner_q;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rdata_d  = '0;
                    rvld0_d  = ~owner_q;
                    rvld1_d  = owner_q;
                    rd_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            RVLD0   <= 1'b0;
            RVLD1   <= 1'b0;
            RD_ERR  <= 1'b0;
            RDATA   <= '0;
            Address <= '0;
            WrData  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            GNT0    <= gnt0_d;
            GNT1    <= gnt1_d;
            WrEn    <= wr_en_d;
            RdEn    <= rd_en_d;
            RVLD0   <= rvld0_d;
            RVLD1   <= rvld1_d;
            RD_ERR  <= rd_err_d;
            RDATA   <= rdata_d;
            Address <= address_d;
            WrData  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// tb/tb_rf_arbiter.sv - self-checking bench for rf_arbiter

module tb_rf_arbiter;

    localparam int TO = 4;

    logic       CLK_IN, RST_IN;
    logic       REQ0, REQ1, WR0, WR1;
    logic [3:0] ADDR0, ADDR1;
    logic [7:0] WDATA0, WDATA1;
    logic       GNT0, GNT1;
    logic [7:0] RDATA;
    logic       RVLD0, RVLD1, RD_ERR;
    logic [3:0] Address;
    logic       WrEn, RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;

    int errors = 0;
    int checks = 0;

    rf_arbiter #(.WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(TO)) dut (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RDATA(RDATA),
        .RVLD0(RVLD0), .RVLD1(RVLD1), .RD_ERR(RD_ERR),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid)
    );

    initial begin
        CLK_IN = 1'b0;
        forever #5 CLK_IN = ~CLK_IN;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // {GNT0,GNT1,WrEn,RdEn,RVLD0,RVLD1,RD_ERR,RDATA,Address,WrData}
    function automatic logic [26:0] pack(input logic g0, g1, we, re, v0, v1, er,
                                         input logic [7:0] rd, input logic [3:0] ad,
                                         input logic [7:0] wd);
        return {g0, g1, we, re, v0, v1, er, rd, ad, wd};
    endfunction

    function automatic logic [26:0] outs();
        return pack(GNT0, GNT1, WrEn, RdEn, RVLD0, RVLD1, RD_ERR, RDATA, Address, WrData);
    endfunction

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic idle_inputs();
        REQ0 = 1'b0; REQ1 = 1'b0; WR0 = 1'b0; WR1 = 1'b0;
        ADDR0 = 4'h0; ADDR1 = 4'h0; WDATA0 = 8'h00; WDATA1 = 8'h00;
        RdData = 8'h00; RdData_Valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_IN = 1'b0;
        tick();
        RST_IN = 1'b1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        string       name;
        logic        req0, req1, wr0, wr1;
        logic [3:0]  a0, a1;
        logic [7:0]  d0, d1;
        logic        rdv;
        logic [7:0]  rdd;
        logic [26:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic r0, r1, w0, w1,
                                input logic [3:0] a0, a1, input logic [7:0] d0, d1,
                                input logic rdv, input logic [7:0] rdd,
                                input logic [26:0] exp);
        vec_t v;
        v.name = n; v.req0 = r0; v.req1 = r1; v.wr0 = w0; v.wr1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.rdv = rdv; v.rdd = rdd;
        v.exp = exp;
        return v;
    endfunction

    vec_t tbl[9];

    // ---------------- behavioural reference model ----------------
    // Transaction view: who was granted last, when a read was granted,
    // and whether the cycle after a write is still being spent.
    int unsigned m_cyc, m_grant_cyc;
    bit          m_reading, m_wr_recover, m_have_last, m_last, m_owner;
    bit          m_g0, m_g1, m_we, m_re, m_v0, m_v1, m_err;
    logic [7:0]  m_rdata, m_wdata;
    logic [3:0]  m_addr;

    task automatic model_reset();
        m_cyc = 0; m_grant_cyc = 0;
        m_reading = 0; m_wr_recover = 0; m_have_last = 0; m_last = 0; m_owner = 0;
        m_g0 = 0; m_g1 = 0; m_we = 0; m_re = 0; m_v0 = 0; m_v1 = 0; m_err = 0;
        m_rdata = 8'h00; m_wdata = 8'h00; m_addr = 4'h0;
    endtask

    task automatic model_step();
        bit fav, w, iswr;
        m_g0 = 0; m_g1 = 0; m_we = 0; m_re = 0; m_v0 = 0; m_v1 = 0; m_err = 0;
        if (m_reading) begin
            if (RdData_Valid) begin
                if (m_owner) m_v1 = 1; else m_v0 = 1;
                m_rdata = RdData;
                m_reading = 0;
            end else if (m_cyc - m_grant_cyc == TO) begin
                if (m_owner) m_v1 = 1; else m_v0 = 1;
                m_err = 1;
                m_rdata = 8'h00;
                m_reading = 0;
            end
        end else if (m_wr_recover) begin
            m_wr_recover = 0;
        end else if (REQ0 || REQ1) begin
            fav  = m_have_last ? !m_last : 1'b0;
            w    = (REQ0 && REQ1) ? fav : REQ1;
            iswr = w ? WR1 : WR0;
            m_have_last = 1; m_last = w; m_owner = w;
            if (w) m_g1 = 1; else m_g0 = 1;
            m_addr  = w ? ADDR1 : ADDR0;
            m_wdata = w ? WDATA1 : WDATA0;
            if (iswr) begin
                m_we = 1; m_wr_recover = 1;
            end else begin
                m_re = 1; m_reading = 1; m_grant_cyc = m_cyc;
            end
        end
        m_cyc++;
    endtask

    initial begin
        RST_IN = 1'b0;
        idle_inputs();
        repeat (2) tick();
        chk("reset_state", outs(), 27'h0);
        RST_IN = 1'b1;

        // Sequential vectors starting from reset: write, read, ignored valid,
        // contention, requests ignored during WR_ACC.
        tbl[0] = mk("wr0_grant",  1,0,1,0, 4'h5,4'h0, 8'h3C,8'h00, 0,8'h00,
                    pack(1,0,1,0,0,0,0, 8'h00, 4'h5, 8'h3C));
        tbl[1] = mk("wr0_after",  0,0,0,0, 4'h0,4'h0, 8'h00,8'h00, 0,8'h00,
                    pack(0,0,0,0,0,0,0, 8'h00, 4'h5, 8'h3C));
        tbl[2] = mk("rd1_grant",  0,1,0,0, 4'h0,4'h2, 8'h00,8'h99, 0,8'h00,
                    pack(0,1,0,1,0,0,0, 8'h00, 4'h2, 8'h99));
        tbl[3] = mk("rd1_return", 0,0,0,0, 4'h0,4'h0, 8'h00,8'h00, 1,8'hA7,
                    pack(0,0,0,0,0,1,0, 8'hA7, 4'h2, 8'h99));
        tbl[4] = mk("rdv_idle",   0,0,0,0, 4'h0,4'h0, 8'h00,8'h00, 1,8'h55,
                    pack(0,0,0,0,0,0,0, 8'hA7, 4'h2, 8'h99));
        tbl[5] = mk("both_wr0",   1,1,1,1, 4'h7,4'h8, 8'h11,8'h22, 0,8'h00,
                    pack(1,0,1,0,0,0,0, 8'hA7, 4'h7, 8'h11));
        tbl[6] = mk("wracc_hold", 0,1,1,1, 4'h7,4'h8, 8'h11,8'h22, 0,8'h00,
                    pack(0,0,0,0,0,0,0, 8'hA7, 4'h7, 8'h11));
        tbl[7] = mk("both_wr1",   0,1,1,1, 4'h7,4'h8, 8'h11,8'h22, 0,8'h00,
                    pack(0,1,1,0,0,0,0, 8'hA7, 4'h8, 8'h22));
        tbl[8] = mk("quiet",      0,0,0,0, 4'h0,4'h0, 8'h00,8'h00, 0,8'h00,
                    pack(0,0,0,0,0,0,0, 8'hA7, 4'h8, 8'h22));

        for (int i = 0; i < 9; i++) begin
            REQ0 = tbl[i].req0; REQ1 = tbl[i].req1; WR0 = tbl[i].wr0; WR1 = tbl[i].wr1;
            ADDR0 = tbl[i].a0; ADDR1 = tbl[i].a1; WDATA0 = tbl[i].d0; WDATA1 = tbl[i].d1;
            RdData_Valid = tbl[i].rdv; RdData = tbl[i].rdd;
            tick();
            chk(tbl[i].name, outs(), tbl[i].exp);
        end

        // Both writers held high from reset: alternate, one grant per 2 cycles.
        do_reset();
        REQ0 = 1; REQ1 = 1; WR0 = 1; WR1 = 1; ADDR0 = 4'h1; ADDR1 = 4'h2;
        for (int e = 1; e <= 8; e++) begin
            logic [1:0] eg;
            tick();
            eg = (e == 1 || e == 5) ? 2'b10 : (e == 3 || e == 7) ? 2'b01 : 2'b00;
            chk($sformatf("rr_edge%0d", e), 27'({GNT0, GNT1}), 27'(eg));
        end

        // Good read, then a read that times out, then a following grant.
        do_reset();
        REQ0 = 1; WR0 = 0; ADDR0 = 4'h3;
        tick();
        REQ0 = 0; RdData_Valid = 1; RdData = 8'hA5;
        tick();
        chk("pre_read_data", 27'({RVLD0, RDATA}), 27'({1'b1, 8'hA5}));
        RdData_Valid = 0;
        REQ1 = 1; WR1 = 0; ADDR1 = 4'hC;
        tick();
        chk("to_grant", 27'({GNT1, RdEn}), 27'(2'b11));
        REQ1 = 0;
        for (int k = 1; k < TO; k++) begin
            tick();
            chk($sformatf("to_wait%0d", k), 27'({RVLD0, RVLD1, RD_ERR}), 27'h0);
        end
        tick();
        chk("to_expire", 27'({RVLD0, RVLD1, RD_ERR, RDATA}), 27'({3'b011, 8'h00}));
        REQ0 = 1; WR0 = 1;
        tick();
        chk("after_to_grant", 27'({GNT0, GNT1, WrEn}), 27'(3'b101));
        REQ0 = 0;

        // Reset while a read is outstanding.
        do_reset();
        REQ0 = 1; WR0 = 0; ADDR0 = 4'h6;
        tick();
        REQ0 = 0; RdData_Valid = 1; RdData = 8'h5A;
        tick();
        RdData_Valid = 0;
        REQ1 = 1; WR1 = 0; ADDR1 = 4'h9;
        tick();
        REQ1 = 0;
        tick();
        #2 RST_IN = 1'b0;
        #1 chk("async_reset_outs", outs(), 27'h0);
        #2 RST_IN = 1'b1;
        RdData_Valid = 1; RdData = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("no_rvld_after_rst%0d", k), 27'({RVLD0, RVLD1, RD_ERR}), 27'h0);
        end
        RdData_Valid = 0;
        REQ1 = 1; WR1 = 1;
        tick();
        chk("post_rst_gnt1", 27'({GNT0, GNT1}), 27'(2'b01));
        REQ1 = 0;

        // Data arriving exactly in the timeout cycle wins.
        do_reset();
        REQ0 = 1; WR0 = 0; ADDR0 = 4'hA;
        tick();
        REQ0 = 0;
        for (int k = 1; k < TO; k++) tick();
        RdData_Valid = 1; RdData = 8'h11;
        tick();
        chk("valid_at_timeout", 27'({RVLD0, RD_ERR, RDATA}), 27'({2'b10, 8'h11}));
        RdData_Valid = 0;

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!REQ0 && $urandom_range(0, 2) == 0) begin
                REQ0 = 1; WR0 = 1'($urandom_range(0, 1));
                ADDR0 = 4'($urandom); WDATA0 = 8'($urandom);
            end
            if (!REQ1 && $urandom_range(0, 2) == 0) begin
                REQ1 = 1; WR1 = 1'($urandom_range(0, 1));
                ADDR1 = 4'($urandom); WDATA1 = 8'($urandom);
            end
            RdData_Valid = ($urandom_range(0, 3) == 0);
            RdData = 8'($urandom);
            model_step();
            tick();
            chk($sformatf("rand_cyc%0d", c), outs(),
                pack(m_g0, m_g1, m_we, m_re, m_v0, m_v1, m_err, m_rdata, m_addr, m_wdata));
            if (m_g0) REQ0 = 0;
            if (m_g1) REQ1 = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of register-file words.
REQ-002 Parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 Parameter RD_TIMEOUT, default 4, maximum wait in cycles for RdData_Valid, range 2..15.
REQ-004 CLK_IN  in  1  clock; all state updates on rising edge.
REQ-005 RST_IN  in  1  reset, asynchronous, active-low.
REQ-006 REQ0, REQ1  in  1 each  access request from requester 0 and 1; held high until the matching GNT.
REQ-007 WR0, WR1  in  1 each  access type, 1 = write, 0 = read; valid while the matching REQ is high.
REQ-008 ADDR0, ADDR1  in  ADDR_WIDTH each  target address.
REQ-009 WDATA0, WDATA1  in  WIDTH each  write data.
REQ-010 GNT0, GNT1  out  1 each  one-cycle accept pulse.
REQ-011 RDATA  out  WIDTH  read data returned to the granted requester.
REQ-012 RVLD0, RVLD1  out  1 each  one-cycle read-return pulse.
REQ-013 RD_ERR  out  1  one-cycle pulse, coincident with RVLDn, on read timeout.
REQ-014 Address  out  ADDR_WIDTH  register-file address.
REQ-015 WrEn, RdEn  out  1 each  register-file strobes.
REQ-016 WrData  out  WIDTH  register-file write data.
REQ-017 RdData  in  WIDTH  register-file read data.
REQ-018 RdData_Valid  in  1  register-file read-data qualifier.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have the states IDLE, WR_ACC and RD_WAIT.
REQ-021 In IDLE with at least one REQ high, on the next edge the arbiter SHALL latch the winner's ADDR and WDATA into Address and WrData, set WrEn = WRn and RdEn = !WRn, pulse GNTn, and move to WR_ACC on a write or RD_WAIT on a read.
REQ-022 Arbitration SHALL be round-robin: a 1-bit pointer names the favoured requester and flips to the non-granted requester on every grant.
REQ-023 The pointer SHALL favour requester 0 after reset.
REQ-024 With a single REQ high, that requester SHALL win regardless of the pointer.
REQ-025 WrEn and RdEn SHALL be high for exactly one cycle per grant.
REQ-026 WR_ACC SHALL return to IDLE on the next edge, giving one write per 2 cycles at best.
REQ-027 Address and WrData SHALL hold their values until the next grant.
REQ-028 RD_WAIT SHALL run a wait counter, cleared on entry and incremented every cycle RdData_Valid is low.
REQ-029 When RdData_Valid is high in RD_WAIT, the arbiter SHALL register RDATA <= RdData, pulse RVLDn for the granted requester, and return to IDLE.
REQ-030 When the counter reaches RD_TIMEOUT-1 with RdData_Valid low, the arbiter SHALL register RDATA <= 0, pulse RVLDn and RD_ERR together, and return to IDLE.
REQ-031 If RdData_Valid arrives in the same cycle as the timeout, it SHALL win: data is returned and RD_ERR stays low.
REQ-032 REQ inputs SHALL be ignored outside IDLE; no request queuing, no grant while a read is outstanding.
REQ-033 RdData_Valid SHALL be ignored outside RD_WAIT.
REQ-034 GNT0 and GNT1 SHALL never be high together; likewise RVLD0 and RVLD1, and WrEn and RdEn.
REQ-035 Grant to RVLD latency SHALL be 1 cycle at minimum and RD_TIMEOUT cycles at maximum.

Reset
REQ-036 On RST_IN low, the block SHALL enter IDLE asynchronously, with the pointer at 0, the counter at 0, and every output at 0.
REQ-037 Reset during RD_WAIT SHALL abandon the read without any RVLD or RD_ERR pulse.
REQ-038 After reset release, the first active edge SHALL evaluate requests from IDLE.

Verification
REQ-039 REQ0 = 1, WR0 = 1, ADDR0 = 4'h5, WDATA0 = 8'h3C -> next cycle GNT0 = 1, WrEn = 1, Address = 5, WrData = 8'h3C; WrEn = 0 the cycle after.
REQ-040 REQ1 read of ADDR1 = 4'h2, RdData_Valid returned 1 cycle after RdEn with RdData = 8'hA7 -> RVLD1 = 1, RDATA = 8'hA7, RD_ERR = 0, RVLD0 = 0.
REQ-041 REQ0 and REQ1 writes held high continuously from reset -> grant order GNT0, GNT1, GNT0, GNT1, one grant every 2 cycles.
REQ-042 Read with RdData_Valid never asserted, RD_TIMEOUT = 4 -> RVLDn = 1, RD_ERR = 1, RDATA = 0, four cycles after RdEn; a next request is granted afterwards.
REQ-043 RST_IN pulsed low in RD_WAIT -> all outputs 0 immediately, no RVLD; a later REQ1-only request is granted GNT1.
REQ-044 RdData_Valid asserted in exactly the timeout cycle with RdData = 8'h11 -> RDATA = 8'h11, RD_ERR = 0.
